// File: rtl/ev10_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : ev10_spi_responder
// Description : ADC-side SPI responder for the EV10AQ190 register protocol.
//               It oversamples a mode-0 SPI bus in the clk domain, holds a
//               register file of NUM_REGS 16-bit words, and reports
//               committed writes to local logic.
//               Frame: 24 bits MSB first = {W/R, A[6:0], D[15:0]}.
//
// Ports       : clk, reset_n      - system clock, synchronous active-low reset
//               spi_cs_n/spi_clk/spi_mosi - SPI inputs (asynchronous pins)
//               spi_miso, spi_miso_oe     - read data and its output enable
//               reg_wr_valid/addr/data    - one-cycle write-commit report
//               cfg_rd_addr/cfg_rd_data   - local registered read port
//               frame_err                 - one-cycle malformed-frame pulse
//
// Config      : EV10_SPI_RESPONDER_RO_ID_EN - when defined, address 0 is a
//               read-only ID register returning CHIP_ID.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ev10_spi_responder #(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] CHIP_ID  = 16'h0190
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_cs_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        reg_wr_valid,
    output logic [6:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    input  logic [6:0]  cfg_rd_addr,
    output logic [15:0] cfg_rd_data,
    output logic        frame_err
);

`ifdef EV10_SPI_RESPONDER_RO_ID_EN
    localparam bit c_RO_ID_EN = 1'b1;
`else
    localparam bit c_RO_ID_EN = 1'b0;
`endif

    localparam int c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Synchronisers and registered edge pulses
    // ------------------------------------------------------------------
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_mosi_s1, r_mosi_s2, r_mosi_s3;
    logic r_cs_fall, r_cs_rise, r_clk_rise, r_clk_fall;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [1:0]  r_state, w_state_nxt;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_shift_in;
    logic [15:0] r_shift_out;
    logic        r_wr;
    logic [6:0]  r_addr;
    logic        r_miso;
    logic        r_oe;
    logic [15:0] r_regs [NUM_REGS];
    logic        r_wr_valid;
    logic [6:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic [15:0] r_cfg_rd_data;
    logic        r_frame_err;

    // FSM decodes
    logic w_clr_cnt, w_inc_cnt, w_shift_in, w_latch_hdr;
    logic w_load, w_shift_out, w_miso_zero, w_capture, w_ferr;

    // Datapath helpers
    logic        w_addr_in_range;
    logic        w_writable;
    logic [15:0] w_rd_word;
    logic [15:0] w_cfg_word;
    logic [15:0] w_wr_word;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (r_cs_rise) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (r_cs_fall) w_state_nxt = c_ST_ADDR;
                c_ST_ADDR: if (r_clk_fall && r_bit_cnt == 5'd8) w_state_nxt = c_ST_DATA;
                c_ST_DATA: if (r_clk_rise && r_bit_cnt == 5'd23) w_state_nxt = c_ST_DONE;
                c_ST_DONE: w_state_nxt = c_ST_DONE;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decodes (all actions suppressed by a deselect)
    // ------------------------------------------------------------------
    always_comb begin
        w_clr_cnt   = 1'b0;
        w_inc_cnt   = 1'b0;
        w_shift_in  = 1'b0;
        w_latch_hdr = 1'b0;
        w_load      = 1'b0;
        w_shift_out = 1'b0;
        w_capture   = 1'b0;
        w_miso_zero = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE) || r_cs_rise;
        // A deselect from IDLE is never an error; that covers the spurious
        // rise seen when the synchronisers leave reset with the bus idle.
        w_ferr      = r_cs_rise && (r_state != c_ST_IDLE) && (r_bit_cnt != 5'd24);
        if (!r_cs_rise) begin
            w_clr_cnt   = (r_state == c_ST_IDLE) && r_cs_fall;
            // Counting continues in DONE so over-long frames are flagged.
            w_inc_cnt   = (r_state != c_ST_IDLE) && r_clk_rise;
            w_shift_in  = ((r_state == c_ST_ADDR) || (r_state == c_ST_DATA)) && r_clk_rise;
            w_latch_hdr = (r_state == c_ST_ADDR) && r_clk_rise && (r_bit_cnt == 5'd7);
            w_load      = (r_state == c_ST_ADDR) && r_clk_fall && (r_bit_cnt == 5'd8) && !r_wr;
            w_shift_out = (r_state == c_ST_DATA) && r_clk_fall && !r_wr;
            w_capture   = (r_state == c_ST_DATA) && r_clk_rise && (r_bit_cnt == 5'd23) && r_wr;
        end
    end

    // ------------------------------------------------------------------
    // Register-file access decodes
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_in_range = (32'(r_addr) < 32'(NUM_REGS));
        w_writable      = w_addr_in_range && !(c_RO_ID_EN && (r_addr == 7'd0));
        w_wr_word       = {r_shift_in[14:0], r_mosi_s3};

        w_rd_word = 16'h0000;
        if (c_RO_ID_EN && (r_addr == 7'd0)) begin
            w_rd_word = CHIP_ID;
        end else if (w_addr_in_range) begin
            w_rd_word = r_regs[r_addr[c_IDX_W-1:0]];
        end

        w_cfg_word = 16'h0000;
        if (c_RO_ID_EN && (cfg_rd_addr == 7'd0)) begin
            w_cfg_word = CHIP_ID;
        end else if (32'(cfg_rd_addr) < 32'(NUM_REGS)) begin
            w_cfg_word = r_regs[cfg_rd_addr[c_IDX_W-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // The chip-select synchronisers reset to "selected" so a bus that
            // is still low after reset cannot look like a new frame start;
            // a real frame needs a high and then a low on the pin.
            r_cs_s1       <= 1'b0;
            r_cs_s2       <= 1'b0;
            r_cs_s3       <= 1'b0;
            r_sck_s1      <= 1'b0;
            r_sck_s2      <= 1'b0;
            r_sck_s3      <= 1'b0;
            r_mosi_s1     <= 1'b0;
            r_mosi_s2     <= 1'b0;
            r_mosi_s3     <= 1'b0;
            r_cs_fall     <= 1'b0;
            r_cs_rise     <= 1'b0;
            r_clk_rise    <= 1'b0;
            r_clk_fall    <= 1'b0;
            r_bit_cnt     <= 5'd0;
            r_shift_in    <= 16'h0000;
            r_shift_out   <= 16'h0000;
            r_wr          <= 1'b0;
            r_addr        <= 7'd0;
            r_miso        <= 1'b0;
            r_oe          <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= 7'd0;
            r_wr_data     <= 16'h0000;
            r_cfg_rd_data <= 16'h0000;
            r_frame_err   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            r_cs_s1   <= spi_cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_sck_s1  <= spi_clk;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_mosi_s3 <= r_mosi_s2;

            r_cs_fall  <= r_cs_s3 & ~r_cs_s2;
            r_cs_rise  <= ~r_cs_s3 & r_cs_s2;
            r_clk_rise <= ~r_sck_s3 & r_sck_s2;
            r_clk_fall <= r_sck_s3 & ~r_sck_s2;

            r_wr_valid  <= 1'b0;
            r_frame_err <= w_ferr;

            if (w_clr_cnt) begin
                r_bit_cnt <= 5'd0;
            end else if (w_inc_cnt && (r_bit_cnt != 5'd31)) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end

            // r_mosi_s3 lines up with the registered edge pulses.
            if (w_shift_in) begin
                r_shift_in <= w_wr_word;
            end

            if (w_latch_hdr) begin
                r_wr   <= r_shift_in[6];
                r_addr <= {r_shift_in[5:0], r_mosi_s3};
            end

            if (w_miso_zero) begin
                r_miso <= 1'b0;
            end else if (w_load) begin
                r_miso      <= w_rd_word[15];
                r_shift_out <= {w_rd_word[14:0], 1'b0};
            end else if (w_shift_out) begin
                r_miso      <= r_shift_out[15];
                r_shift_out <= {r_shift_out[14:0], 1'b0};
            end

            if (r_cs_rise) begin
                r_oe <= 1'b0;
            end else if (w_load) begin
                r_oe <= 1'b1;
            end

            if (w_capture && w_writable) begin
                r_regs[r_addr[c_IDX_W-1:0]] <= w_wr_word;
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_wr_word;
            end

            r_cfg_rd_data <= w_cfg_word;
        end
    end

    assign spi_miso     = r_miso;
    assign spi_miso_oe  = r_oe;
    assign reg_wr_valid = r_wr_valid;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign cfg_rd_data  = r_cfg_rd_data;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ev10_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ev10_spi_responder
// Description : Directed self-checking bench for ev10_spi_responder. Drives
//               mode-0 SPI frames with 6-clk phases and checks write
//               commits, read-back data, frame errors and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ev10_spi_responder;

    localparam int PH = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic [6:0]  cfg_rd_addr = 7'd0;
    wire         spi_miso;
    wire         spi_miso_oe;
    wire         reg_wr_valid;
    wire  [6:0]  reg_wr_addr;
    wire  [15:0] reg_wr_data;
    wire  [15:0] cfg_rd_data;
    wire         frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int ferr_cnt = 0;
    logic [6:0]  wr_addr_seen = 7'd0;
    logic [15:0] wr_data_seen = 16'h0000;

    ev10_spi_responder #(.NUM_REGS(16), .CHIP_ID(16'h0190)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_wr_valid(reg_wr_valid),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_data (cfg_rd_data),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor
    always @(negedge clk) begin
        if (reg_wr_valid) begin
            wr_cnt++;
            wr_addr_seen = reg_wr_addr;
            wr_data_seen = reg_wr_data;
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        spi_cs_n = 1'b0;
        wait_clk(PH);
    endtask

    // Clocks bits first..last of a frame; collects MISO at each rise of bits 8..23.
    task automatic spi_bits(input logic [23:0] word, input int first, input int last,
                            output logic [15:0] rd, output bit oe_ok);
        rd = 16'h0000;
        oe_ok = 1'b1;
        for (int i = first; i <= last; i++) begin
            spi_mosi = word[23-i];
            wait_clk(PH);
            if (i >= 8) begin
                rd = {rd[14:0], spi_miso};
                if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
            end
            spi_clk = 1'b1;
            wait_clk(PH);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_end();
        wait_clk(PH);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(3 * PH);
    endtask

    task automatic spi_frame(input logic [23:0] word, input int nbits,
                             output logic [15:0] rd, output bit oe_ok);
        spi_begin();
        spi_bits(word, 0, nbits - 1, rd, oe_ok);
        spi_end();
    endtask

    task automatic cfg_read(input logic [6:0] a, output logic [15:0] d);
        cfg_rd_addr = a;
        wait_clk(2);
        d = cfg_rd_data;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        wait_clk(5);
        n_cmp++; if (spi_miso !== 1'b0)          begin n_bad++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        n_cmp++; if (spi_miso_oe !== 1'b0)       begin n_bad++; $display("FAIL reset_oe: got %b expected 0", spi_miso_oe); end
        n_cmp++; if (reg_wr_valid !== 1'b0)      begin n_bad++; $display("FAIL reset_wr_valid: got %b expected 0", reg_wr_valid); end
        n_cmp++; if (reg_wr_addr !== 7'd0)       begin n_bad++; $display("FAIL reset_wr_addr: got %h expected 00", reg_wr_addr); end
        n_cmp++; if (reg_wr_data !== 16'h0000)   begin n_bad++; $display("FAIL reset_wr_data: got %h expected 0000", reg_wr_data); end
        n_cmp++; if (cfg_rd_data !== 16'h0000)   begin n_bad++; $display("FAIL reset_cfg_rd: got %h expected 0000", cfg_rd_data); end
        n_cmp++; if (frame_err !== 1'b0)         begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        reset_n = 1'b1;
        wait_clk(10);
        n_cmp++; if (ferr_cnt !== 0 || wr_cnt !== 0) begin n_bad++; $display("FAIL reset_release_pulses: got ferr=%0d wr=%0d expected 0/0", ferr_cnt, wr_cnt); end
    endtask

    task automatic test_write_read();
        logic [15:0] rd, d;
        bit oe_ok;
        int wr0, fe0;
        wr0 = wr_cnt; fe0 = ferr_cnt;
        spi_frame(24'h85A55A, 24, rd, oe_ok);
        n_cmp++; if (wr_cnt !== wr0 + 1)        begin n_bad++; $display("FAIL wr_pulse_count: got %0d expected %0d", wr_cnt - wr0, 1); end
        n_cmp++; if (wr_addr_seen !== 7'h05)    begin n_bad++; $display("FAIL wr_addr: got %h expected 05", wr_addr_seen); end
        n_cmp++; if (wr_data_seen !== 16'hA55A) begin n_bad++; $display("FAIL wr_data: got %h expected a55a", wr_data_seen); end
        // Read back; check MISO returns to 0 in DONE while OE stays up.
        spi_begin();
        spi_bits(24'h050000, 0, 23, rd, oe_ok);
        wait_clk(PH);
        n_cmp++; if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b1) begin n_bad++; $display("FAIL done_miso_oe: got miso=%b oe=%b expected 0/1", spi_miso, spi_miso_oe); end
        spi_end();
        n_cmp++; if (rd !== 16'hA55A)           begin n_bad++; $display("FAIL spi_readback: got %h expected a55a", rd); end
        n_cmp++; if (oe_ok !== 1'b1)            begin n_bad++; $display("FAIL read_oe: got %b expected 1", oe_ok); end
        n_cmp++; if (spi_miso_oe !== 1'b0)      begin n_bad++; $display("FAIL oe_after_cs: got %b expected 0", spi_miso_oe); end
        cfg_read(7'd5, d);
        n_cmp++; if (d !== 16'hA55A)            begin n_bad++; $display("FAIL cfg_read5: got %h expected a55a", d); end
        n_cmp++; if (ferr_cnt !== fe0 || wr_cnt !== wr0 + 1) begin n_bad++; $display("FAIL wr_rd_side_pulses: got ferr=%0d wr=%0d expected 0/1", ferr_cnt - fe0, wr_cnt - wr0); end
    endtask

    task automatic test_short_frame();
        logic [15:0] rd, d;
        bit oe_ok;
        int wr0, fe0;
        spi_frame(24'h831111, 24, rd, oe_ok);
        wr0 = wr_cnt; fe0 = ferr_cnt;
        spi_frame(24'h83BEEF, 20, rd, oe_ok);
        n_cmp++; if (ferr_cnt !== fe0 + 1)      begin n_bad++; $display("FAIL short_ferr: got %0d expected 1", ferr_cnt - fe0); end
        n_cmp++; if (wr_cnt !== wr0)            begin n_bad++; $display("FAIL short_no_wr: got %0d expected 0", wr_cnt - wr0); end
        cfg_read(7'd3, d);
        n_cmp++; if (d !== 16'h1111)            begin n_bad++; $display("FAIL short_reg3: got %h expected 1111", d); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd;
        bit oe_ok;
        int wr0, fe0;
        wr0 = wr_cnt; fe0 = ferr_cnt;
        spi_frame(24'hC01234, 24, rd, oe_ok);
        n_cmp++; if (wr_cnt !== wr0)            begin n_bad++; $display("FAIL oor_no_wr: got %0d expected 0", wr_cnt - wr0); end
        n_cmp++; if (ferr_cnt !== fe0)          begin n_bad++; $display("FAIL oor_no_ferr: got %0d expected 0", ferr_cnt - fe0); end
        spi_frame(24'h400000, 24, rd, oe_ok);
        n_cmp++; if (rd !== 16'h0000)           begin n_bad++; $display("FAIL oor_read: got %h expected 0000", rd); end
        n_cmp++; if (oe_ok !== 1'b1)            begin n_bad++; $display("FAIL oor_oe: got %b expected 1", oe_ok); end
    endtask

    task automatic test_addr0();
        logic [15:0] rd, d;
        bit oe_ok;
        int wr0;
`ifdef EV10_SPI_RESPONDER_RO_ID_EN
        spi_frame(24'h000000, 24, rd, oe_ok);
        n_cmp++; if (rd !== 16'h0190)           begin n_bad++; $display("FAIL id_read: got %h expected 0190", rd); end
        wr0 = wr_cnt;
        spi_frame(24'h801234, 24, rd, oe_ok);
        n_cmp++; if (wr_cnt !== wr0)            begin n_bad++; $display("FAIL id_write_dropped: got %0d expected 0", wr_cnt - wr0); end
        spi_frame(24'h000000, 24, rd, oe_ok);
        n_cmp++; if (rd !== 16'h0190)           begin n_bad++; $display("FAIL id_reread: got %h expected 0190", rd); end
        cfg_read(7'd0, d);
        n_cmp++; if (d !== 16'h0190)            begin n_bad++; $display("FAIL id_cfg_read: got %h expected 0190", d); end
`else
        spi_frame(24'h000000, 24, rd, oe_ok);
        n_cmp++; if (rd !== 16'h0000)           begin n_bad++; $display("FAIL a0_read_init: got %h expected 0000", rd); end
        wr0 = wr_cnt;
        spi_frame(24'h801234, 24, rd, oe_ok);
        n_cmp++; if (wr_cnt !== wr0 + 1 || wr_addr_seen !== 7'd0) begin n_bad++; $display("FAIL a0_write: got cnt=%0d addr=%h expected 1/00", wr_cnt - wr0, wr_addr_seen); end
        spi_frame(24'h000000, 24, rd, oe_ok);
        n_cmp++; if (rd !== 16'h1234)           begin n_bad++; $display("FAIL a0_reread: got %h expected 1234", rd); end
        cfg_read(7'd0, d);
        n_cmp++; if (d !== 16'h1234)            begin n_bad++; $display("FAIL a0_cfg_read: got %h expected 1234", d); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] rd, d;
        bit oe_ok;
        int wr0, fe0;
        wr0 = wr_cnt; fe0 = ferr_cnt;
        spi_begin();
        spi_bits(24'h87DEAD, 0, 11, rd, oe_ok);
        reset_n = 1'b0;
        wait_clk(1);
        n_cmp++; if ({spi_miso, spi_miso_oe, reg_wr_valid, frame_err} !== 4'b0000) begin n_bad++; $display("FAIL midrst_bits: got %b expected 0000", {spi_miso, spi_miso_oe, reg_wr_valid, frame_err}); end
        n_cmp++; if (reg_wr_addr !== 7'd0 || reg_wr_data !== 16'h0000) begin n_bad++; $display("FAIL midrst_wr_bus: got %h/%h expected 00/0000", reg_wr_addr, reg_wr_data); end
        n_cmp++; if (cfg_rd_data !== 16'h0000)  begin n_bad++; $display("FAIL midrst_cfg: got %h expected 0000", cfg_rd_data); end
        wait_clk(1);
        reset_n = 1'b1;
        // Remaining bits with chip select still low must be ignored.
        spi_bits(24'h87DEAD, 12, 23, rd, oe_ok);
        spi_end();
        n_cmp++; if (wr_cnt !== wr0 || ferr_cnt !== fe0) begin n_bad++; $display("FAIL midrst_no_commit: got wr=%0d ferr=%0d expected 0/0", wr_cnt - wr0, ferr_cnt - fe0); end
        cfg_read(7'd7, d);
        n_cmp++; if (d !== 16'h0000)            begin n_bad++; $display("FAIL midrst_reg7: got %h expected 0000", d); end
        cfg_read(7'd5, d);
        n_cmp++; if (d !== 16'h0000)            begin n_bad++; $display("FAIL midrst_reg5_cleared: got %h expected 0000", d); end
        spi_frame(24'h870F0F, 24, rd, oe_ok);
        n_cmp++; if (wr_cnt !== wr0 + 1 || wr_addr_seen !== 7'h07 || wr_data_seen !== 16'h0F0F) begin n_bad++; $display("FAIL clean_write: got cnt=%0d addr=%h data=%h expected 1/07/0f0f", wr_cnt - wr0, wr_addr_seen, wr_data_seen); end
        cfg_read(7'd7, d);
        n_cmp++; if (d !== 16'h0F0F)            begin n_bad++; $display("FAIL clean_reg7: got %h expected 0f0f", d); end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_write_read();
                test_short_frame();
                test_out_of_range();
                test_addr0();
                test_reset_mid_frame();
            end
            begin
                wait_clk(60000);
                n_cmp++; n_bad++;
                $display("FAIL timeout: got %0d clk expected completion", 60000);
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ev10_spi_responder.md
# ev10_spi_responder

Synthesizable SPI responder that implements the EV10AQ190 register-access protocol as seen from the ADC side of the serial link. It terminates the `spi_cs_n`/`spi_clk`/`spi_mosi`/`spi_miso` bus driven by the `ev10aq190` controller's SPI master and holds a register file. It reports completed writes to local logic. It serves as the closed-loop bench partner for the controller and as an FPGA-side emulator when no ADC is fitted. All SPI pins are oversampled in the single `clk` domain; `spi_clk` is treated as data, not as a clock.

## Interface

- `NUM_REGS`, 16 — number of implemented 16-bit registers, addresses 0..NUM_REGS-1, max 128.
- `CHIP_ID`, 16'h0190 — value returned at address 0 when the read-only ID is compiled in.
- `clk` in 1 — system clock; the only clock.
- `reset_n` in 1 — synchronous, active-low reset.
- `spi_cs_n` in 1 — frame select, active low.
- `spi_clk` in 1 — SPI clock, mode 0 (idle low).
- `spi_mosi` in 1 — serial data from the master.
- `spi_miso` out 1 — serial read data to the master.
- `spi_miso_oe` out 1 — high while driving read data; the top level builds the tristate.
- `reg_wr_valid` out 1 — one-cycle pulse when a write commits.
- `reg_wr_addr` out 7 — committed address; valid with `reg_wr_valid`.
- `reg_wr_data` out 16 — committed data; valid with `reg_wr_valid`.
- `cfg_rd_addr` in 7 — local read address.
- `cfg_rd_data` out 16 — local read data, registered.
- `frame_err` out 1 — one-cycle pulse on a malformed frame.

## Operation

- **Frame format:** 24 bits, MSB first.
  - Bit 23: W/R, where 1 = write and 0 = read.
  - Bits 22..16: address A[6:0].
  - Bits 15..0: data D[15:0].
- **Input synchronisation:** `spi_cs_n`, `spi_clk` and `spi_mosi` each pass through 2 flops. Edge detect compares the second flop against a third flop.
- **Sampling:** MOSI is sampled on each detected `spi_clk` rise. MISO changes only on a detected fall.
- **State machine:**
  - IDLE → ADDR on a detected `spi_cs_n` fall; the bit counter clears to 0.
  - ADDR: shift 8 bits. On the 8th rise, latch W/R and address.
    - Read: on the 8th fall, load the shift-out register with the addressed register, or 16'h0000 if the address ≥ NUM_REGS.
    - Read: drive D15 on `spi_miso` and raise `spi_miso_oe`.
    - Then go to DATA.
  - DATA: shift 16 bits.
    - Read: MISO advances one bit per fall.
    - Write: on the 24th rise, capture D; go to DONE.
  - DONE: ignore further edges; MISO stays 0.
  - Any state → IDLE on a detected `spi_cs_n` rise.
- **Write commit:** happens in the clk after the 24th rise when the address < NUM_REGS.
  - Update the register.
  - Pulse `reg_wr_valid` with the address and data.
  - If the address ≥ NUM_REGS, drop the write: no pulse, no error.
- **Bit counter:** 5 bits, saturating at 31. On a `spi_cs_n` rise with count ≠ 24, pulse `frame_err` and commit nothing.
- **Local read port:** `cfg_rd_data` is the register at `cfg_rd_addr`, one clk later; out-of-range addresses return 0. A same-cycle SPI commit to that address is visible on the following read.
- **Reset mid-frame:** the state machine returns to IDLE and nothing is committed. The next frame is recognised only after `spi_cs_n` goes high and then low again.

## Timing

- **Reset values:**
  - `spi_miso`=0, `spi_miso_oe`=0.
  - `reg_wr_valid`=0, `reg_wr_addr`=0, `reg_wr_data`=0.
  - `cfg_rd_data`=0, `frame_err`=0.
  - All registers are 0.
- **Pin-to-edge-detect latency:** 3 clk.
- **MISO update:** registered; changes 4 clk after the `spi_clk` falling pin edge.
- **Timing requirement:** each `spi_clk` high and low phase lasts ≥ 4 clk, and `spi_cs_n` setup and hold to `spi_clk` is ≥ 4 clk. Faster traffic is unsupported.
- **Write latency:** `reg_wr_valid` asserts 4 clk after the 24th rising pin edge.
- **Output enable:** `spi_miso_oe` falls 4 clk after `spi_cs_n` rises.

## Configuration

- `EV10_SPI_RESPONDER_RO_ID_EN`:
  - **Defined:** address 0 is read-only and returns `CHIP_ID` on SPI and local reads. Writes to address 0 are dropped without a `reg_wr_valid` pulse.
  - **Undefined:** address 0 is an ordinary read/write register.

## Test plan

- **Write then read back:** write A=0x05, D=0xA55A.
  - Expect one `reg_wr_valid` pulse with addr 0x05 and data 0xA55A.
  - A following read frame of A=0x05 returns 0xA55A MSB-first on `spi_miso`.
  - `cfg_rd_addr`=5 gives `cfg_rd_data`=0xA55A.
- **Short frame:** `spi_cs_n` rises after 20 bits of a write to A=0x03.
  - Expect a `frame_err` pulse, no `reg_wr_valid`, and register 3 unchanged.
- **Out-of-range address (`NUM_REGS`=16):** write A=0x40, then read A=0x40.
  - Expect no write pulse.
  - The read returns 0x0000 with `spi_miso_oe` high during the data bits.
- **Macro defined:** read A=0x00 → 0x0190. Write A=0x00, D=0x1234 → no pulse; a re-read still gives 0x0190.
- **Macro undefined:** read A=0x00 returns the last value written (0 after reset).
- **Reset mid-frame:** assert `reset_n` low for 2 clk after 12 bits of a write, then complete a clean write frame.
  - Expect no commit from the aborted frame and a correct commit of the clean frame.
  - All outputs read their reset values during reset.
